vec_store_sequencer: RTL and testbench
======================================

// Module: vec_store_sequencer
// PURPOSE
// - Upstream stage of the 24-bit vector data memory: turns one vector-store request into a burst of 8-lane writes.
// - Reads each 8-lane beat from the vector register source and drives memory address, we and wd.
// - Holds each beat stable long enough for the memory's two-stage address pipeline.
// - Toggles the memory's startIO (dump trigger) on completion when the request asks for it.
// PARAMETERS
// - WIDTH         24     lane / address width
// - VECTOR_WIDTH  8      lanes per beat
// - DEPTH         10000  memory words
// - ADDR_OFFSET   24     memory accepts addresses in [ADDR_OFFSET, ADDR_OFFSET+DEPTH)
// - MAX_BEATS     16     maximum beats per request
// - BEAT_CYCLES   3      cycles mem_we is held per beat (>=3)
// PORTS
// - clk           in   1                     clock
// - rst           in   1                     synchronous reset, active-high
// - req_valid     in   1                     store request valid
// - req_ready     out  1                     sequencer can accept a request
// - req_base      in   WIDTH                 data word index of first element (0-based)
// - req_beats     in   $clog2(MAX_BEATS+1)   beats to store, 1..MAX_BEATS
// - req_dump      in   1                     toggle startIO when done
// - src_rd_en     out  1                     source read strobe
// - src_rd_idx    out  $clog2(MAX_BEATS)     beat index being read
// - src_rd_data   in   VECTOR_WIDTH x WIDTH  beat data, valid 1 cycle after src_rd_en
// - mem_we        out  1                     memory write enable
// - mem_address   out  WIDTH                 memory address
// - mem_wd        out  VECTOR_WIDTH x WIDTH  memory write data
// - startIO       out  1                     dump trigger (level toggle)
// - done          out  1                     1-cycle pulse: request finished
// - err           out  1                     1-cycle pulse: request rejected
// BEHAVIOUR
// - Reset values:
//   - req_ready=1; src_rd_en=0; src_rd_idx=0; mem_we=0; mem_address=0; mem_wd=0; startIO=0; done=0; err=0.
//   - FSM goes to IDLE. Reset mid-burst abandons the burst at the next edge; no further writes.
// - Handshake: accept when req_valid && req_ready. Latch base, beats, dump. req_ready=1 only in IDLE.
// - Range check at accept:
//   - Reject if req_beats==0, req_beats>MAX_BEATS, or req_base+VECTOR_WIDTH*req_beats > DEPTH.
//   - Width rule: compute the bound WIDTH+8 bits wide; no overflow.
//   - Reject -> ERR state: err=1 for one cycle, no reads, no writes, then IDLE.
// - FSM: IDLE -> FETCH -> WAIT -> WRITE -> (FETCH | DONE) -> IDLE.
//   - FETCH (1 cycle): src_rd_en=1, src_rd_idx=beat.
//   - WAIT (1 cycle): capture src_rd_data into mem_wd register.
//   - WRITE (BEAT_CYCLES cycles):
//     - mem_we=1; mem_address=ADDR_OFFSET+req_base+VECTOR_WIDTH*beat.
//     - mem_wd held constant throughout.
//     - Leaving WRITE: mem_we=0 and beat++. Go to FETCH if beat<beats, else DONE.
//   - DONE (1 cycle): done=1. If the latched dump bit is set, startIO inverts on the same edge.
// - Outputs are registered. Latency per beat = 2+BEAT_CYCLES cycles.
// - Request accept to done pulse = beats*(2+BEAT_CYCLES)+1 cycles.
// - mem_address and mem_wd hold their last values while mem_we=0.
// - req_valid while busy is ignored (not queued); the requester holds it.
// STRUCTURE
// - Shared package vec_mem_pkg:
//   - WIDTH, VECTOR_WIDTH, DEPTH and ADDR_OFFSET constants.
//   - typedef lane_t (logic [WIDTH-1:0]) and vec_t (lane_t [VECTOR_WIDTH-1:0]).
//   - enum seq_state_t {IDLE, FETCH, WAIT, WRITE, DONE, ERR}.
// - One sub-module: vec_store_range_chk, a combinational accept/reject from base and beats.
// - Everything else lives in a single FSM plus beat and hold counters.
// TESTING
// - Basic request:
//   - Stimulus: base=0, beats=1, dump=0, source beat 0 lanes = 0x000001..0x000008.
//   - Required: mem_we high exactly 3 cycles with address=24 and wd unchanged.
//   - Required: done pulses 6 cycles after accept; startIO stays 0.
// - Multi-beat request:
//   - Stimulus: base=100, beats=4.
//   - Required: addresses 124, 132, 140, 148, in order, each held 3 cycles.
//   - Required: src_rd_idx steps 0..3; done 21 cycles after accept.
// - Dump toggle:
//   - Stimulus: two back-to-back requests with dump=1.
//   - Required: startIO goes 0->1 on the first done and 1->0 on the second.
//   - Required: req_ready=0 between accept and done.
// - Range boundary:
//   - base=9992, beats=1 is accepted (last address 10016).
//   - base=9993, beats=1 gives an err pulse and no mem_we.
//   - beats=0 and beats=17 also give err.
// - Reset mid-burst:
//   - Stimulus: assert rst during the second WRITE of a 4-beat request.
//   - Required: next cycle mem_we=0 and req_ready=1; no done pulse.
//   - Required: a fresh request then completes normally.
// - Busy ignore:
//   - Stimulus: pulse req_valid with different base during a burst.
//   - Required: no change to the address sequence; that request is not taken.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared constants, lane/vector types and sequencer states for the vector data memory
package vec_mem_pkg;

    localparam int WIDTH        = 24;
    localparam int VECTOR_WIDTH = 8;
    localparam int DEPTH        = 10000;
    localparam int ADDR_OFFSET  = 24;

    typedef logic [WIDTH-1:0] lane_t;
    typedef lane_t [VECTOR_WIDTH-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        DONE,
        ERR
    } seq_state_t;

endpackage

// File: rtl/vec_store_range_chk.sv
// rtl/vec_store_range_chk.sv - combinational accept/reject of a store request from base and beat count
module vec_store_range_chk
    import vec_mem_pkg::*;
#(
    parameter  int MAX_BEATS = 16,
    localparam int BEATS_W   = $clog2(MAX_BEATS + 1)
) (
    input  lane_t              i_base,
    input  logic [BEATS_W-1:0] i_beats,
    output logic               o_ok
);

    // The end bound is formed 8 bits wider than a lane so a base near the top
    // of the lane range cannot wrap around and look like a small address.
    localparam int BW = WIDTH + 8;

    logic [BW-1:0] w_bound;

    assign w_bound = BW'(i_base) + BW'(i_beats) * BW'(VECTOR_WIDTH);

    assign o_ok = (i_beats != '0)
               && (i_beats <= BEATS_W'(MAX_BEATS))
               && (w_bound <= BW'(DEPTH));

endmodule

// File: rtl/vec_store_sequencer.sv
// rtl/vec_store_sequencer.sv - turns one vector-store request into a burst of held 8-lane memory writes
module vec_store_sequencer
    import vec_mem_pkg::*;
#(
    parameter  int MAX_BEATS   = 16,
    parameter  int BEAT_CYCLES = 3,
    localparam int BEATS_W     = $clog2(MAX_BEATS + 1),
    localparam int IDX_W       = $clog2(MAX_BEATS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  lane_t              req_base,
    input  logic [BEATS_W-1:0] req_beats,
    input  logic               req_dump,
    output logic               src_rd_en,
    output logic [IDX_W-1:0]   src_rd_idx,
    input  vec_t               src_rd_data,
    output logic               mem_we,
    output lane_t              mem_address,
    output vec_t               mem_wd,
    output logic               startIO,
    output logic               done,
    output logic               err
);

    localparam int                HOLD_W    = $clog2(BEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BEAT_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [BEATS_W-1:0] r_beat;
    logic [BEATS_W-1:0] w_beat_nxt;
    logic [BEATS_W-1:0] w_beat_inc;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nxt;
    lane_t              r_base;
    logic [BEATS_W-1:0] r_beats;
    logic               r_dump;
    logic               w_range_ok;
    lane_t              w_wr_addr;

    logic               r_req_ready;
    logic               r_src_rd_en;
    logic [IDX_W-1:0]   r_src_rd_idx;
    logic               r_mem_we;
    lane_t              r_mem_address;
    vec_t               r_mem_wd;
    logic               r_start_io;
    logic               r_done;
    logic               r_err;

    vec_store_range_chk #(
        .MAX_BEATS (MAX_BEATS)
    ) u_range_chk (
        .i_base  (req_base),
        .i_beats (req_beats),
        .o_ok    (w_range_ok)
    );

    assign w_beat_inc = r_beat + BEATS_W'(1);
    assign w_wr_addr  = lane_t'(ADDR_OFFSET) + r_base + lane_t'(r_beat) * lane_t'(VECTOR_WIDTH);

    // Next state plus beat/hold counter updates for the burst walk.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = w_range_ok ? FETCH : ERR;
                end
            end
            FETCH: w_state_nxt = WAIT;
            WAIT: begin
                w_hold_nxt  = '0;
                w_state_nxt = WRITE;
            end
            WRITE: begin
                if (r_hold == HOLD_LAST) begin
                    w_beat_nxt  = w_beat_inc;
                    w_state_nxt = (w_beat_inc < r_beats) ? FETCH : DONE;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and counter registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_hold  <= '0;
            r_base  <= '0;
            r_beats <= '0;
            r_dump  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_hold  <= w_hold_nxt;
            if (r_state == IDLE && req_valid) begin
                r_base  <= req_base;
                r_beats <= req_beats;
                r_dump  <= req_dump;
            end
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready   <= 1'b1;
            r_src_rd_en   <= 1'b0;
            r_src_rd_idx  <= '0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
            r_mem_wd      <= '0;
            r_start_io    <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_src_rd_en <= (w_state_nxt == FETCH);
            r_mem_we    <= (w_state_nxt == WRITE);
            r_done      <= (w_state_nxt == DONE);
            r_err       <= (w_state_nxt == ERR);
            if (w_state_nxt == FETCH) begin
                r_src_rd_idx <= w_beat_nxt[IDX_W-1:0];
            end
            // Source data is valid during WAIT; address and data then stay frozen
            // until the next beat's WAIT, so the memory sees a stable beat.
            if (r_state == WAIT) begin
                r_mem_wd      <= src_rd_data;
                r_mem_address <= w_wr_addr;
            end
            if (w_state_nxt == DONE && r_dump) begin
                r_start_io <= ~r_start_io;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign src_rd_en   = r_src_rd_en;
    assign src_rd_idx  = r_src_rd_idx;
    assign mem_we      = r_mem_we;
    assign mem_address = r_mem_address;
    assign mem_wd      = r_mem_wd;
    assign startIO     = r_start_io;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_vec_store_sequencer.sv
// tb/tb_vec_store_sequencer.sv - self-checking bench for vec_store_sequencer against a cycle-timeline reference model
module tb_vec_store_sequencer;
    import vec_mem_pkg::*;

    localparam int MAX_BEATS   = 16;
    localparam int BEAT_CYCLES = 3;
    localparam int BEAT_LEN    = 2 + BEAT_CYCLES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    lane_t       req_base = '0;
    logic [4:0]  req_beats = '0;
    logic        req_dump = 1'b0;
    logic        src_rd_en;
    logic [3:0]  src_rd_idx;
    vec_t        src_rd_data = '0;
    logic        mem_we;
    lane_t       mem_address;
    vec_t        mem_wd;
    logic        startIO;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    vec_t  src_mem [MAX_BEATS];
    logic  exp_start_io;
    lane_t exp_last_addr;
    vec_t  exp_last_wd;

    vec_store_sequencer #(
        .MAX_BEATS   (MAX_BEATS),
        .BEAT_CYCLES (BEAT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_base    (req_base),
        .req_beats   (req_beats),
        .req_dump    (req_dump),
        .src_rd_en   (src_rd_en),
        .src_rd_idx  (src_rd_idx),
        .src_rd_data (src_rd_data),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wd      (mem_wd),
        .startIO     (startIO),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Vector register source: data valid for exactly the cycle after a read strobe, junk otherwise.
    always @(posedge clk) begin
        if (src_rd_en === 1'b1) begin
            #1 src_rd_data = src_mem[src_rd_idx];
        end else begin
            #1;
            for (int l = 0; l < VECTOR_WIDTH; l++) src_rd_data[l] = lane_t'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_src();
        for (int b = 0; b < MAX_BEATS; b++)
            for (int l = 0; l < VECTOR_WIDTH; l++)
                src_mem[b][l] = lane_t'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 192'(req_ready), 192'(1));
        chk({tag, "_we"}, 192'(mem_we), 192'(0));
        chk({tag, "_done"}, 192'(done), 192'(0));
        chk({tag, "_err"}, 192'(err), 192'(0));
        chk({tag, "_rden"}, 192'(src_rd_en), 192'(0));
        chk({tag, "_addr"}, 192'(mem_address), 192'(exp_last_addr));
        chk({tag, "_wd"}, mem_wd, exp_last_wd);
        chk({tag, "_startio"}, 192'(startIO), 192'(exp_start_io));
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle(tag);
        end
    endtask

    // Issue one request starting at a negedge and check every cycle until the
    // sequencer is ready again. abort_at > 0 asserts reset after that cycle.
    task automatic run_req(input lane_t base, input int beats, input bit dump,
                           input bit busy_poke, input int abort_at, input string tag);
        bit  ok;
        int  n;
        int  beat;
        int  phase;
        bit  exp_we;
        bit  exp_rd;
        bit  poke;
        ok = (beats >= 1) && (beats <= MAX_BEATS) &&
             (longint'(base) + longint'(VECTOR_WIDTH * beats) <= longint'(DEPTH));
        n = ok ? beats * BEAT_LEN + 1 : 1;
        poke = busy_poke && ok && (beats >= 2);
        chk({tag, "_ready_pre"}, 192'(req_ready), 192'(1));
        req_valid = 1'b1;
        req_base  = base;
        req_beats = 5'(beats);
        req_dump  = dump;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 6) begin
                req_valid = 1'b1;
                req_base  = base + 24'd800;
                req_beats = 5'd1;
            end
            if (poke && k == 8) req_valid = 1'b0;
            beat   = (k - 1) / BEAT_LEN;
            phase  = (k - 1) % BEAT_LEN;
            exp_we = ok && (k < n) && (phase >= 2);
            exp_rd = ok && (k < n) && (phase == 0);
            if (ok && k == n && dump) exp_start_io = ~exp_start_io;
            if (exp_we) begin
                exp_last_addr = lane_t'(ADDR_OFFSET) + base + lane_t'(VECTOR_WIDTH * beat);
                exp_last_wd   = src_mem[beat];
            end
            chk({tag, "_ready"}, 192'(req_ready), 192'(k == n + 1));
            chk({tag, "_done"}, 192'(done), 192'(ok && k == n));
            chk({tag, "_err"}, 192'(err), 192'(!ok && k == 1));
            chk({tag, "_we"}, 192'(mem_we), 192'(exp_we));
            chk({tag, "_rden"}, 192'(src_rd_en), 192'(exp_rd));
            if (exp_rd) chk({tag, "_rdidx"}, 192'(src_rd_idx), 192'(beat));
            chk({tag, "_addr"}, 192'(mem_address), 192'(exp_last_addr));
            chk({tag, "_wd"}, mem_wd, exp_last_wd);
            chk({tag, "_startio"}, 192'(startIO), 192'(exp_start_io));
            if (abort_at > 0 && k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_start_io  = 1'b0;
                exp_last_addr = '0;
                exp_last_wd   = '0;
                check_idle({tag, "_rst"});
                break;
            end
        end
    endtask

    initial begin
        exp_start_io  = 1'b0;
        exp_last_addr = '0;
        exp_last_wd   = '0;
        fill_src();

        // Reset values, checked while reset is held and once released.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_rdidx", 192'(src_rd_idx), 192'(0));
        rst = 1'b0;
        idle_cycles(2, "post_reset");

        // Basic single beat with lanes 1..8.
        for (int l = 0; l < VECTOR_WIDTH; l++) src_mem[0][l] = lane_t'(l + 1);
        run_req(24'd0, 1, 1'b0, 1'b0, 0, "basic");

        // Multi-beat burst.
        fill_src();
        run_req(24'd100, 4, 1'b0, 1'b0, 0, "multi");

        // Back-to-back dump requests toggle startIO up then down.
        fill_src();
        run_req(24'd500, 2, 1'b1, 1'b0, 0, "dump1");
        run_req(24'd600, 3, 1'b1, 1'b0, 0, "dump2");

        // Range boundaries, including a base that would wrap a lane-width sum.
        run_req(24'd9992, 1, 1'b0, 1'b0, 0, "edge_ok");
        run_req(24'd9993, 1, 1'b0, 1'b0, 0, "edge_bad");
        run_req(24'd50, 0, 1'b0, 1'b0, 0, "beats0");
        run_req(24'd50, 17, 1'b1, 1'b0, 0, "beats17");
        run_req(24'hFFFFF8, 1, 1'b0, 1'b0, 0, "wrap");
        fill_src();
        run_req(24'd9872, 16, 1'b0, 1'b0, 0, "max_ok");
        run_req(24'd9873, 16, 1'b0, 1'b0, 0, "max_bad");

        // A second request presented mid-burst is ignored.
        fill_src();
        run_req(24'd300, 3, 1'b0, 1'b1, 0, "busy");
        idle_cycles(3, "busy_after");

        // Reset during the second beat's write window, then a clean request.
        fill_src();
        run_req(24'd200, 4, 1'b1, 1'b0, 9, "abort");
        idle_cycles(4, "abort_after");
        fill_src();
        run_req(24'd200, 4, 1'b1, 1'b0, 0, "fresh");

        // Randomised requests around and away from the range boundary.
        for (int i = 0; i < 16; i++) begin
            lane_t rb;
            int    rn;
            fill_src();
            rb = $urandom_range(0, 1) ? lane_t'($urandom_range(0, 9900))
                                      : lane_t'($urandom_range(9850, 10050));
            rn = $urandom_range(0, 17);
            run_req(rb, rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rand");
        end
        idle_cycles(2, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
